execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: DATA_W, default 8, register and ALU data width.
REQ-002 Parameter: NREG, default 32, number of registers; it SHALL equal 2^5, matching the 5-bit address fields.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rstN  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  op/addr fields carry an instruction this cycle.
REQ-006 Port: op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 Port: addr1  input  5  source register A.
REQ-008 Port: addr2  input  5  source register B.
REQ-009 Port: addr3  input  5  destination register.
REQ-010 Port: init_we  input  1  external register-file write enable, for preload.
REQ-011 Port: init_addr  input  5  external write address.
REQ-012 Port: init_data  input  DATA_W  external write data.
REQ-013 Port: dbg_addr  input  5  debug read address.
REQ-014 Port: dbg_data  output  DATA_W  combinational RF[dbg_addr] (0 for address 0).
REQ-015 Port: wb_valid  output  1  registered; a writeback occurred at the last edge.
REQ-016 Port: wb_addr  output  5  registered destination of the last writeback.
REQ-017 Port: wb_data  output  DATA_W  registered ALU result of the last writeback.
REQ-018 Port: zero, carry  output  1 each  registered flags of the last writeback.
REQ-019 Port: retired_cnt  output  16  count of writebacks.

Function
REQ-020 The pipeline SHALL have two stages:
  - E1: at edge k with in_valid=1, capture op, addr3, operand A and operand B, and set e1_valid.
  - E2: at edge k+1, compute from the E1 registers, write RF[addr3], and update the wb_* outputs.
REQ-021 Latency SHALL be 2 edges from sampling an instruction to wb_valid=1, with throughput of one instruction per cycle and no stalls.
REQ-022 An edge with in_valid=0 SHALL clear e1_valid, so the following edge produces wb_valid=0.
REQ-023 Operand read bypass: when e1_valid=1 and the E1 destination equals addr1/addr2 (nonzero), the operand SHALL be the current ALU result rather than the RF value.
REQ-024 Register 0 SHALL read as 0 always; writes to it SHALL be discarded and never bypassed, while wb_valid/wb_addr/wb_data still report the result.
REQ-025 ADD: result = (A+B) mod 2^DATA_W; carry = bit DATA_W of the sum.
REQ-026 SUB: result = (A-B) mod 2^DATA_W; carry = 1 iff A<B (unsigned borrow).
REQ-027 AND/OR: bitwise result; carry = 0.
REQ-028 zero SHALL be 1 iff result == 0.
REQ-029 zero and carry SHALL update only on edges that perform a writeback and hold otherwise.
REQ-030 wb_addr and wb_data SHALL also hold when wb_valid=0.
REQ-031 init_we SHALL write RF[init_addr] at the edge; an instruction sampled at that same edge SHALL see the old value.
REQ-032 If init_we and a writeback target the same nonzero address at the same edge, the writeback SHALL win; writes to different addresses SHALL both occur.
REQ-033 retired_cnt SHALL increment by 1 per writeback, including to register 0, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-034 When rstN=0, asynchronously:
  - all RF entries, e1_valid, wb_valid, wb_addr, wb_data, zero, carry and retired_cnt SHALL be 0;
  - in-flight instructions SHALL be discarded.
REQ-035 The first instruction sampled after rstN deasserts SHALL produce wb_valid two edges later.

Verification
REQ-036 Basic ADD (DATA_W=8): init R1=0x05, R2=0x03; issue ADD R3=R1+R2 -> wb_valid=1, wb_addr=3, wb_data=0x08, carry=0, zero=0; dbg_addr=3 -> dbg_data=0x08.
REQ-037 Back-to-back bypass: R1=0x05, R2=0x03; consecutive ADD R3=R1+R2, SUB R4=R3-R1 -> writebacks 0x08 then 0x03 on consecutive cycles.
REQ-038 ADD overflow: R1=0xFF, R2=0x01, ADD -> 0x00, carry=1, zero=1.
REQ-039 SUB borrow: R1=0x03, R2=0x05, SUB -> 0xFE, carry=1, zero=0.
REQ-040 Register 0: ADD R0=R1+R2 with R1=0x05, R2=0x03 -> wb_data=0x08, wb_addr=0, but dbg R0=0x00; an immediately following OR R5=R0|R0 -> 0x00.
REQ-041 Write collision: init_we to R3=0xAA on the same edge as the writeback of R3=0x08 -> R3=0x08.
REQ-042 Reset mid-operation: issue an instruction, pull rstN low before its writeback -> wb_valid=0, all registers 0, retired_cnt=0; no writeback after release.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage
//   A two-stage ALU execute pipeline with its own register file.
//   E1 samples an instruction and reads its operands. Operands come from the
//   register file, or are forwarded from the instruction currently in E1.
//   E2 computes the result, writes it back and publishes it on the wb_* outputs.
//
// Ports
//   clk, rstN            rising-edge clock; asynchronous active-low reset
//   in_valid, op         instruction strobe and opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//   addr1, addr2, addr3  source A, source B, destination register
//   init_we/addr/data    external register-file preload port
//   dbg_addr, dbg_data   combinational register-file peek (R0 reads 0)
//   wb_valid/addr/data   registered writeback report
//   zero, carry          registered flags of the last writeback
//   retired_cnt          wrapping count of writebacks
module execute_stage #(
    parameter int DATA_W = 8,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic [4:0]        addr1,
    input  logic [4:0]        addr2,
    input  logic [4:0]        addr3,
    input  logic              init_we,
    input  logic [4:0]        init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero,
    output logic              carry,
    output logic [15:0]       retired_cnt
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    // Returns {carry, result}. For SUB, the extra top bit of the widened
    // difference is the unsigned borrow.
    function automatic logic [DATA_W:0] alu(input logic [1:0]        f,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (f)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] rf [NREG];

    logic              vld_p1;
    logic [1:0]        op_p1;
    logic [4:0]        dst_p1;
    logic [DATA_W-1:0] opa_p1;
    logic [DATA_W-1:0] opb_p1;

    logic [DATA_W:0]   alu_p1;
    logic [DATA_W-1:0] res_p1;
    logic              cry_p1;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    assign alu_p1 = alu(op_p1, opa_p1, opb_p1);
    assign res_p1 = alu_p1[DATA_W-1:0];
    assign cry_p1 = alu_p1[DATA_W];

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // Operand fetch. The E1 destination is compared only against nonzero source
    // addresses, so a result aimed at R0 is never forwarded.
    always_comb begin
        opa = '0;
        opb = '0;
        if (addr1 != 5'd0) begin
            if (vld_p1 && (dst_p1 == addr1)) opa = res_p1;
            else                             opa = rf[addr1];
        end
        if (addr2 != 5'd0) begin
            if (vld_p1 && (dst_p1 == addr2)) opb = res_p1;
            else                             opb = rf[addr2];
        end
    end

    // ---- E1 boundary: instruction capture ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) vld_p1 <= 1'b0;
        else       vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            op_p1  <= op;
            dst_p1 <= addr3;
            opa_p1 <= opa;
            opb_p1 <= opb;
        end
    end

    // ---- E2 boundary: writeback ----
    // The writeback assignment comes after the preload assignment, so it wins
    // when both target the same register at the same edge. R0 is never stored.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (init_we && (init_addr != 5'd0)) rf[init_addr] <= init_data;
            if (vld_p1 && (dst_p1 != 5'd0))     rf[dst_p1]    <= res_p1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            retired_cnt <= '0;
        end else begin
            wb_valid <= vld_p1;
            if (vld_p1) begin
                wb_addr     <= dst_p1;
                wb_data     <= res_p1;
                zero        <= (res_p1 == '0);
                carry       <= cry_p1;
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end

endmodule
